// File: rtl/gdiv_pkg.sv
// Shared types and encodings for the Goldschmidt divider controller.
package gdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_N0   = 3'd1,
    ST_D0   = 3'd2,
    ST_NI   = 3'd3,
    ST_DI   = 3'd4,
    ST_FIN  = 3'd5,
    ST_DONE = 3'd6
  } gdiv_state_t;

  localparam logic [1:0] ND_SEL_D    = 2'b00;
  localparam logic [1:0] ND_SEL_N    = 2'b01;
  localparam logic [1:0] ND_SEL_NEWD = 2'b10;
  localparam logic [1:0] ND_SEL_NEWN = 2'b11;

endpackage

// File: rtl/gdiv_controller_flopenr.sv
// Enabled register with asynchronous active-high reset, used for operand capture.
module flopenr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/gdiv_controller.sv
// Goldschmidt divider sequencer: captures operands, steps the datapath, returns the quotient.
// Optional divide-by-zero short-cut and dz flag enabled by defining GDIV_DZ_EN.
module gdiv_controller
  import gdiv_pkg::*;
#(
  parameter int unsigned ITERATIONS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] n_in,
  input  logic [15:0] d_in,
  input  logic [15:0] ia_in,
  output logic [15:0] dp_n,
  output logic [15:0] dp_d,
  output logic [15:0] dp_ia,
  output logic [1:0]  ndSelect,
  output logic        kSelect,
  output logic        nEnable,
  output logic        dEnable,
  input  logic [15:0] dp_result,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef GDIV_DZ_EN
  output logic        dz,
`endif
  output logic [15:0] q_out
);

  localparam int unsigned CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 2);

  gdiv_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             rst_h;

  assign rst_h  = ~reset;
  assign accept = in_valid && in_ready;

  flopenr #(.WIDTH(16)) u_n_reg  (.clk(clk), .reset(rst_h), .en(accept), .d(n_in),  .q(dp_n));
  flopenr #(.WIDTH(16)) u_d_reg  (.clk(clk), .reset(rst_h), .en(accept), .d(d_in),  .q(dp_d));
  flopenr #(.WIDTH(16)) u_ia_reg (.clk(clk), .reset(rst_h), .en(accept), .d(ia_in), .q(dp_ia));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef GDIV_DZ_EN
          state_d = (d_in == '0) ? ST_DONE : ST_N0;
`else
          state_d = ST_N0;
`endif
        end
      end
      ST_N0: state_d = ST_D0;
      ST_D0: state_d = (ITERATIONS == 1) ? ST_FIN : ST_NI;
      ST_NI: state_d = ST_DI;
      ST_DI: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIN;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_NI;
        end
      end
      ST_FIN:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // N is always written before D in a pass: K is derived from the current D.
  always_comb begin
    ndSelect  = ND_SEL_D;
    kSelect   = 1'b0;
    nEnable   = 1'b0;
    dEnable   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_N0: begin
        ndSelect = ND_SEL_N;
        nEnable  = 1'b1;
      end
      ST_D0: begin
        ndSelect = ND_SEL_D;
        dEnable  = 1'b1;
      end
      ST_NI: begin
        ndSelect = ND_SEL_NEWN;
        kSelect  = 1'b1;
        nEnable  = 1'b1;
      end
      ST_DI: begin
        ndSelect = ND_SEL_NEWD;
        kSelect  = 1'b1;
        dEnable  = 1'b1;
      end
      ST_FIN: begin
        ndSelect = ND_SEL_NEWN;
        kSelect  = 1'b1;
        dEnable  = 1'b1;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef GDIV_DZ_EN
  logic dz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= (d_in == '0);
    end
  end

  assign dz    = (state_q == ST_DONE) && dz_q;
  assign q_out = dz ? '1 : dp_result;
`else
  assign q_out = dp_result;
`endif

endmodule

// File: tb/tb_gdiv_controller.sv
// Directed, table-driven bench for gdiv_controller with ITERATIONS=3.
module tb_gdiv_controller;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n_in, d_in, ia_in;
  logic [15:0] dp_n, dp_d, dp_ia;
  logic [1:0]  ndSelect;
  logic        kSelect, nEnable, dEnable;
  logic [15:0] dp_result;
  logic        out_valid, out_ready;
  logic [15:0] q_out;
`ifdef GDIV_DZ_EN
  logic        dz;
`endif

  gdiv_controller #(.ITERATIONS(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .d_in(d_in), .ia_in(ia_in),
    .dp_n(dp_n), .dp_d(dp_d), .dp_ia(dp_ia),
    .ndSelect(ndSelect), .kSelect(kSelect), .nEnable(nEnable), .dEnable(dEnable),
    .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef GDIV_DZ_EN
    .dz(dz),
`endif
    .q_out(q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] nd;
    logic       ks;
    logic       ne;
    logic       de;
    logic       ov;
  } step_t;

  typedef struct {
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] ia;
    logic [15:0] res;
  } op_t;

  step_t seq [8];
  op_t   ops [4];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_step(input string tag, input int k);
    chk($sformatf("%s ndSelect[%0d]", tag, k), {14'b0, ndSelect}, {14'b0, seq[k].nd});
    chk($sformatf("%s kSelect[%0d]", tag, k), {15'b0, kSelect}, {15'b0, seq[k].ks});
    chk($sformatf("%s nEnable[%0d]", tag, k), {15'b0, nEnable}, {15'b0, seq[k].ne});
    chk($sformatf("%s dEnable[%0d]", tag, k), {15'b0, dEnable}, {15'b0, seq[k].de});
    chk($sformatf("%s out_valid[%0d]", tag, k), {15'b0, out_valid}, {15'b0, seq[k].ov});
    chk($sformatf("%s in_ready[%0d]", tag, k), {15'b0, in_ready}, 16'd0);
  endtask

  // Starts in IDLE just after an edge; ends in DONE (release=0) or back in IDLE (release=1).
  task automatic run_op(input string tag, input op_t o, input bit release_done);
    n_in = o.n; d_in = o.d; ia_in = o.ia; dp_result = o.res;
    in_valid = 1'b1;
    chk({tag, " in_ready idle"}, {15'b0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, " dp_n"}, dp_n, o.n);
    chk({tag, " dp_d"}, dp_d, o.d);
    chk({tag, " dp_ia"}, dp_ia, o.ia);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check_step(tag, k);
    end
    chk({tag, " q_out"}, q_out, o.res);
    if (release_done) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " out_valid after handshake"}, {15'b0, out_valid}, 16'd0);
      chk({tag, " in_ready after handshake"}, {15'b0, in_ready}, 16'd1);
    end
  endtask

  initial begin
    seq[0] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    seq[1] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    seq[2] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    seq[3] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    seq[4] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    seq[5] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    seq[6] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0};
    seq[7] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    ops[0] = '{16'h4000, 16'h6000, 16'h5555, 16'h2AAB};
    ops[1] = '{16'h7FFF, 16'h4000, 16'h8000, 16'h7FFF};
    ops[2] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0000};
    ops[3] = '{16'h3C00, 16'h5A00, 16'h5B05, 16'h2AAB};

    // 1: reset with in_valid high
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    n_in = 16'hAAAA; d_in = 16'h5555; ia_in = 16'h1234; dp_result = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", {15'b0, in_ready}, 16'd1);
    chk("rst out_valid", {15'b0, out_valid}, 16'd0);
    chk("rst strobes", {12'b0, ndSelect, kSelect, nEnable}, 16'd0);
    chk("rst dEnable", {15'b0, dEnable}, 16'd0);
    chk("rst dp_n", dp_n, 16'd0);
    chk("rst dp_d", dp_d, 16'd0);
    chk("rst dp_ia", dp_ia, 16'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();

    // 2: per-cycle sequences over the operand table
    for (int i = 0; i < 4; i++) run_op($sformatf("op%0d", i), ops[i], 1'b1);

    // 3: stall in DONE while in_valid is pulsed
    run_op("stall", ops[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; n_in = 16'hBEEF; d_in = 16'h1111; ia_in = 16'h2222;
      tick();
      chk($sformatf("stall q_out[%0d]", c), q_out, ops[0].res);
      chk($sformatf("stall out_valid[%0d]", c), {15'b0, out_valid}, 16'd1);
      chk($sformatf("stall in_ready[%0d]", c), {15'b0, in_ready}, 16'd0);
      chk($sformatf("stall dp_n[%0d]", c), dp_n, ops[0].n);
      chk($sformatf("stall nEnable[%0d]", c), {15'b0, nEnable}, 16'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall release in_ready", {15'b0, in_ready}, 16'd1);

    // 4: back-to-back with in_valid held high
    n_in = ops[1].n; d_in = ops[1].d; ia_in = ops[1].ia; dp_result = ops[1].res;
    in_valid = 1'b1;
    tick();
    n_in = ops[2].n; d_in = ops[2].d; ia_in = ops[2].ia;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check_step("b2b first", k);
    end
    chk("b2b first dp_n held", dp_n, ops[1].n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b gap in_ready", {15'b0, in_ready}, 16'd1);
    chk("b2b gap out_valid", {15'b0, out_valid}, 16'd0);
    chk("b2b gap nEnable", {15'b0, nEnable}, 16'd0);
    chk("b2b gap dp_n", dp_n, ops[1].n);
    dp_result = ops[2].res;
    tick();
    in_valid = 1'b0;
    chk("b2b second dp_n", dp_n, ops[2].n);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check_step("b2b second", k);
    end
    chk("b2b second q_out", q_out, ops[2].res);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5: reset during the second DI
    n_in = ops[3].n; d_in = ops[3].d; ia_in = ops[3].ia; dp_result = ops[3].res;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check_step("pre-reset", 5);
    reset = 1'b0;
    #1;
    chk("midrst in_ready", {15'b0, in_ready}, 16'd1);
    chk("midrst strobes", {12'b0, ndSelect, kSelect, nEnable}, 16'd0);
    chk("midrst dEnable", {15'b0, dEnable}, 16'd0);
    chk("midrst dp_n", dp_n, 16'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("postrst out_valid[%0d]", c), {15'b0, out_valid}, 16'd0);
    end
    run_op("after-reset", ops[0], 1'b1);

    // 6: zero denominator
`ifdef GDIV_DZ_EN
    n_in = 16'h1234; d_in = 16'h0000; ia_in = 16'h4000; dp_result = 16'h0F0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("dz out_valid[%0d]", c), {15'b0, out_valid}, 16'd1);
      chk($sformatf("dz q_out[%0d]", c), q_out, 16'hFFFF);
      chk($sformatf("dz flag[%0d]", c), {15'b0, dz}, 16'd1);
      chk($sformatf("dz strobes[%0d]", c), {13'b0, nEnable, dEnable, kSelect}, 16'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("dz cleared", {15'b0, dz}, 16'd0);
`else
    run_op("dzero", '{16'h1234, 16'h0000, 16'h4000, 16'h0F0F}, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
